// File: rtl/cmplx_mult_stream_if.sv
// ---------------------------------------------------------------------------
// cmplx_mult_stream_if
// Streaming bus for the complex multiplier: an input side (operand pair +
// conjugate flag under valid/ready) and an output side (product + element
// index/last tag under valid/ready).
//
// Parameters
//   W      width of each signed real/imag component
//   IDX_W  width of the element index tag
//
// Modports
//   slave  : the multiplier (consumes operands, produces products)
//   master : the environment (produces operands, consumes products)
// ---------------------------------------------------------------------------
interface cmplx_mult_stream_if #(
  parameter int W     = 16,
  parameter int IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a_re;
  logic signed [W-1:0] a_im;
  logic signed [W-1:0] b_re;
  logic signed [W-1:0] b_im;
  logic                conj_b;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] p_re;
  logic signed [W-1:0] p_im;
  logic [IDX_W-1:0]    p_idx;
  logic                p_last;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready,
    output in_ready, out_valid, p_re, p_im, p_idx, p_last
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready,
    input  in_ready, out_valid, p_re, p_im, p_idx, p_last
  );
endinterface

// File: rtl/cmplx_mult_stream.sv
// ---------------------------------------------------------------------------
// cmplx_mult_stream
// Three-stage pipelined fixed-point complex multiplier for the DFT datapath.
// Accepts one complex pair per cycle, optionally conjugates B, scales the
// product by 2^-FRAC with optional round-half-up, saturates to W bits and
// tags each result with its element index within a FRAME-point vector.
//
// Parameters
//   W      signed component width (inputs and outputs)
//   FRAC   fractional bits removed from the full-precision product
//   FRAME  elements per vector (>= 2)
//   ROUND  1 = round half up before scaling, 0 = truncate toward -inf
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clear  synchronous clear of the index counter and the ovf flag
//   ovf    sticky flag, set when any result component saturated
//   bus    slave side of cmplx_mult_stream_if (operands in, products out)
// ---------------------------------------------------------------------------
module cmplx_mult_stream #(
  parameter int W     = 16,
  parameter int FRAC  = 15,
  parameter int FRAME = 16,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  output logic               ovf,
  cmplx_mult_stream_if.slave bus
);

  localparam int IDX_W = $clog2(FRAME);
  localparam int SW    = 2 * W + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
  localparam int                   RND_SH  = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [SW-1:0] RND_ONE = SW'(1);
  localparam logic signed [SW-1:0] RND_K   = (ROUND != 0 && FRAC > 0) ? (RND_ONE <<< RND_SH) : '0;

  // Optional round-half-up followed by the arithmetic scale by 2^-FRAC.
  function automatic logic signed [SW-1:0] scale(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    t = x + RND_K;
    return t >>> FRAC;
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[W-1:0];
    if (x < SAT_MIN) return SAT_MIN[W-1:0];
    return x[W-1:0];
  endfunction

  // Flow control: every stage moves together whenever the output register
  // is empty or being drained this cycle.
  logic adv;
  logic accept;

  assign adv          = !vld_p2 || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  // Index assignment. A clear in the same cycle as an acceptance gives the
  // accepted beat index 0, so the counter moves on from 0 rather than from
  // its stale value.
  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] idx_cur;
  logic [IDX_W-1:0] idx_next;
  logic             last_cur;

  assign idx_cur  = clear ? '0 : idx_cnt;
  assign last_cur = (idx_cur == IDX_W'(FRAME - 1));
  assign idx_next = last_cur ? '0 : idx_cur + IDX_W'(1);

  // Pipeline registers
  logic                   vld_p0;
  logic signed [W-1:0]    a_re_p0;
  logic signed [W-1:0]    a_im_p0;
  logic signed [W-1:0]    b_re_p0;
  logic signed [W-1:0]    b_im_p0;
  logic                   conj_p0;
  logic [IDX_W-1:0]       idx_p0;
  logic                   last_p0;

  logic                   vld_p1;
  logic signed [2*W-1:0]  prod_rr_p1;
  logic signed [2*W-1:0]  prod_ii_p1;
  logic signed [2*W-1:0]  prod_ri_p1;
  logic signed [2*W-1:0]  prod_ir_p1;
  logic                   conj_p1;
  logic [IDX_W-1:0]       idx_p1;
  logic                   last_p1;

  logic                   vld_p2;
  logic signed [W-1:0]    re_p2;
  logic signed [W-1:0]    im_p2;
  logic [IDX_W-1:0]       idx_p2;
  logic                   last_p2;

  // Sum / scale / saturate feeding the output register
  logic signed [SW-1:0] rr_x;
  logic signed [SW-1:0] ii_x;
  logic signed [SW-1:0] ri_x;
  logic signed [SW-1:0] ir_x;
  logic signed [SW-1:0] sum_re;
  logic signed [SW-1:0] sum_im;
  logic signed [SW-1:0] scl_re;
  logic signed [SW-1:0] scl_im;
  logic                 clip_re;
  logic                 clip_im;

  assign rr_x    = SW'(prod_rr_p1);
  assign ii_x    = SW'(prod_ii_p1);
  assign ri_x    = SW'(prod_ri_p1);
  assign ir_x    = SW'(prod_ir_p1);
  assign sum_re  = conj_p1 ? (rr_x + ii_x) : (rr_x - ii_x);
  assign sum_im  = conj_p1 ? (ir_x - ri_x) : (ri_x + ir_x);
  assign scl_re  = scale(sum_re);
  assign scl_im  = scale(sum_im);
  assign clip_re = clips(scl_re);
  assign clip_im = clips(scl_im);

  // Control path and output register (reset to a known, quiet state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      idx_cnt <= '0;
      ovf     <= 1'b0;
      re_p2   <= '0;
      im_p2   <= '0;
      idx_p2  <= '0;
      last_p2 <= 1'b0;
    end else begin
      if (adv) begin
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end

      if (accept)     idx_cnt <= idx_next;
      else if (clear) idx_cnt <= '0;

      // A saturating beat landing in the same cycle as clear wins.
      if (adv && vld_p1 && (clip_re || clip_im)) ovf <= 1'b1;
      else if (clear)                            ovf <= 1'b0;

      // ---- stage p2: scaled, saturated result ----
      if (adv && vld_p1) begin
        re_p2   <= sat(scl_re);
        im_p2   <= sat(scl_im);
        idx_p2  <= idx_p1;
        last_p2 <= last_p1;
      end
    end
  end

  // Datapath registers (no reset; qualified by the travelling valid bits)
  always_ff @(posedge clk) begin
    if (adv) begin
      // ---- stage p0: captured operands and index tag ----
      a_re_p0 <= bus.a_re;
      a_im_p0 <= bus.a_im;
      b_re_p0 <= bus.b_re;
      b_im_p0 <= bus.b_im;
      conj_p0 <= bus.conj_b;
      idx_p0  <= idx_cur;
      last_p0 <= last_cur;

      // ---- stage p1: four partial products ----
      prod_rr_p1 <= (2*W)'(a_re_p0) * (2*W)'(b_re_p0);
      prod_ii_p1 <= (2*W)'(a_im_p0) * (2*W)'(b_im_p0);
      prod_ri_p1 <= (2*W)'(a_re_p0) * (2*W)'(b_im_p0);
      prod_ir_p1 <= (2*W)'(a_im_p0) * (2*W)'(b_re_p0);
      conj_p1    <= conj_p0;
      idx_p1     <= idx_p0;
      last_p1    <= last_p0;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.p_re      = re_p2;
  assign bus.p_im      = im_p2;
  assign bus.p_idx     = idx_p2;
  assign bus.p_last    = last_p2;

endmodule

// File: tb/tb_cmplx_mult_stream.sv
// ---------------------------------------------------------------------------
// tb_cmplx_mult_stream
// Three instances share one input stream: dut_a (FRAC=15, ROUND=1),
// dut_b (FRAC=15, ROUND=0) and dut_c (FRAC=0, ROUND=1). Expected results
// come from an arithmetic model of the complex product and a queue.
// ---------------------------------------------------------------------------
module tb_cmplx_mult_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  cmplx_mult_stream_if #(.W(16), .IDX_W(4)) ifa ();
  cmplx_mult_stream_if #(.W(16), .IDX_W(4)) ifb ();
  cmplx_mult_stream_if #(.W(16), .IDX_W(4)) ifc ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.a_re      = ifa.a_re;
  assign ifb.a_im      = ifa.a_im;
  assign ifb.b_re      = ifa.b_re;
  assign ifb.b_im      = ifa.b_im;
  assign ifb.conj_b    = ifa.conj_b;
  assign ifb.out_ready = ifa.out_ready;
  assign ifc.in_valid  = ifa.in_valid;
  assign ifc.a_re      = ifa.a_re;
  assign ifc.a_im      = ifa.a_im;
  assign ifc.b_re      = ifa.b_re;
  assign ifc.b_im      = ifa.b_im;
  assign ifc.conj_b    = ifa.conj_b;
  assign ifc.out_ready = ifa.out_ready;

  cmplx_mult_stream #(.W(16), .FRAC(15), .FRAME(16), .ROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ovf(ovf_a), .bus(ifa));
  cmplx_mult_stream #(.W(16), .FRAC(15), .FRAME(16), .ROUND(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ovf(ovf_b), .bus(ifb));
  cmplx_mult_stream #(.W(16), .FRAC(0), .FRAME(16), .ROUND(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ovf(ovf_c), .bus(ifc));

  typedef struct {
    logic signed [15:0] re_a, im_a, re_b, im_b, re_c, im_c;
    logic [3:0]         idx;
    logic               last;
    bit                 clip_a;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_idx = 0;

  // Mathematical reference: full-precision complex product, optional
  // half-up rounding, scale by 2^-frac, clamp to 16-bit signed.
  function automatic void model(input int ar, ai, br, bi, input bit cj, input int frac,
                                input bit rnd, output int re, output int im, output bit clip);
    longint sr, si;
    if (cj) begin
      sr = longint'(ar) * br + longint'(ai) * bi;
      si = longint'(ai) * br - longint'(ar) * bi;
    end else begin
      sr = longint'(ar) * br - longint'(ai) * bi;
      si = longint'(ar) * bi + longint'(ai) * br;
    end
    if (rnd && frac > 0) begin
      sr = sr + (longint'(1) << (frac - 1));
      si = si + (longint'(1) << (frac - 1));
    end
    sr = sr >>> frac;
    si = si >>> frac;
    clip = 1'b0;
    if (sr > 32767) begin sr = 32767; clip = 1'b1; end
    else if (sr < -32768) begin sr = -32768; clip = 1'b1; end
    if (si > 32767) begin si = 32767; clip = 1'b1; end
    else if (si < -32768) begin si = -32768; clip = 1'b1; end
    re = int'(sr);
    im = int'(si);
  endfunction

  function automatic void push_exp(input int ar, ai, br, bi, input bit cj);
    exp_t e;
    int   re, im;
    bit   c;
    model(ar, ai, br, bi, cj, 15, 1'b1, re, im, c);
    e.re_a = 16'(re); e.im_a = 16'(im); e.clip_a = c;
    model(ar, ai, br, bi, cj, 15, 1'b0, re, im, c);
    e.re_b = 16'(re); e.im_b = 16'(im);
    model(ar, ai, br, bi, cj, 0, 1'b1, re, im, c);
    e.re_c = 16'(re); e.im_c = 16'(im);
    e.idx  = 4'(exp_idx);
    e.last = (exp_idx == 15);
    sbq.push_back(e);
    exp_idx = (exp_idx + 1) % 16;
  endfunction

  function automatic logic signed [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return -16'sd32768;
      1:       return 16'sd32767;
      2:       return 16'sd0;
      3:       return -16'sd1;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge, then report whether the
  // coming rising edge accepts an input beat and/or consumes an output.
  task automatic step(input logic iv, input logic signed [15:0] ar, ai, br, bi,
                      input logic cj, input logic ordy, input logic clr,
                      output logic acc, output logic got);
    @(negedge clk);
    ifa.in_valid  = iv;
    ifa.a_re      = ar;
    ifa.a_im      = ai;
    ifa.b_re      = br;
    ifa.b_im      = bi;
    ifa.conj_b    = cj;
    ifa.out_ready = ordy;
    clear         = clr;
    #1;
    acc = ifa.in_valid && ifa.in_ready;
    got = ifa.out_valid && ifa.out_ready;
  endtask

  // Send one beat and wait (bounded) for out_valid; outputs left for the caller.
  task automatic send_and_wait(input logic signed [15:0] ar, ai, br, bi, input logic cj,
                               output bit seen, output int lat);
    logic acc, got;
    step(1'b1, ar, ai, br, bi, cj, 1'b1, 1'b0, acc, got);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
      lat++;
      if (ifa.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid); end
    n_tests++; if (ifa.p_re !== 16'sd0) begin n_fail++; $display("FAIL reset_p_re: got %0d expected 0", ifa.p_re); end
    n_tests++; if (ifa.p_im !== 16'sd0) begin n_fail++; $display("FAIL reset_p_im: got %0d expected 0", ifa.p_im); end
    n_tests++; if (ifa.p_idx !== 4'd0) begin n_fail++; $display("FAIL reset_p_idx: got %0d expected 0", ifa.p_idx); end
    n_tests++; if (ifa.p_last !== 1'b0) begin n_fail++; $display("FAIL reset_p_last: got %b expected 0", ifa.p_last); end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf_a); end
    rst_n = 1'b1;
    exp_idx = 0;
    #1;
    n_tests++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready); end
  endtask

  task automatic test_real();
    bit seen;
    int lat;
    send_and_wait(16'sd16384, 16'sd0, 16'sd16384, 16'sd0, 1'b0, seen, lat);
    n_tests++; if (!seen || lat != 3) begin n_fail++; $display("FAIL real_latency: got %0d cycles (seen=%0d) expected 3", lat, seen); end
    n_tests++; if (ifa.p_re !== 16'sd8192) begin n_fail++; $display("FAIL real_re: got %0d expected 8192", ifa.p_re); end
    n_tests++; if (ifa.p_im !== 16'sd0) begin n_fail++; $display("FAIL real_im: got %0d expected 0", ifa.p_im); end
    n_tests++; if (ifa.p_idx !== 4'd0) begin n_fail++; $display("FAIL real_idx: got %0d expected 0", ifa.p_idx); end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL real_ovf: got %b expected 0", ovf_a); end
    exp_idx = 1;
  endtask

  task automatic test_conj();
    bit seen;
    int lat;
    send_and_wait(16'sd16384, 16'sd16384, 16'sd16384, -16'sd16384, 1'b0, seen, lat);
    n_tests++; if (!seen || ifa.p_re !== 16'sd16384) begin n_fail++; $display("FAIL cmplx_re: got %0d expected 16384", ifa.p_re); end
    n_tests++; if (ifa.p_im !== 16'sd0) begin n_fail++; $display("FAIL cmplx_im: got %0d expected 0", ifa.p_im); end
    n_tests++; if (ifa.p_idx !== 4'd1) begin n_fail++; $display("FAIL cmplx_idx: got %0d expected 1", ifa.p_idx); end
    send_and_wait(16'sd16384, 16'sd16384, 16'sd16384, -16'sd16384, 1'b1, seen, lat);
    n_tests++; if (!seen || ifa.p_re !== 16'sd0) begin n_fail++; $display("FAIL conj_re: got %0d expected 0", ifa.p_re); end
    n_tests++; if (ifa.p_im !== 16'sd16384) begin n_fail++; $display("FAIL conj_im: got %0d expected 16384", ifa.p_im); end
    n_tests++; if (ifa.p_idx !== 4'd2) begin n_fail++; $display("FAIL conj_idx: got %0d expected 2", ifa.p_idx); end
    exp_idx = 3;
  endtask

  task automatic test_round();
    bit seen;
    int lat;
    send_and_wait(16'sd1, 16'sd0, 16'sd16384, 16'sd0, 1'b0, seen, lat);
    n_tests++; if (!seen || ifa.p_re !== 16'sd1) begin n_fail++; $display("FAIL round_pos_r1: got %0d expected 1", ifa.p_re); end
    n_tests++; if (ifb.p_re !== 16'sd0) begin n_fail++; $display("FAIL round_pos_r0: got %0d expected 0", ifb.p_re); end
    send_and_wait(-16'sd1, 16'sd0, 16'sd16384, 16'sd0, 1'b0, seen, lat);
    n_tests++; if (!seen || ifa.p_re !== 16'sd0) begin n_fail++; $display("FAIL round_neg_r1: got %0d expected 0", ifa.p_re); end
    n_tests++; if (ifb.p_re !== -16'sd1) begin n_fail++; $display("FAIL round_neg_r0: got %0d expected -1", ifb.p_re); end
    exp_idx = 5;
  endtask

  task automatic test_saturation();
    bit   seen;
    int   lat;
    logic acc, got;
    send_and_wait(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0, 1'b0, seen, lat);
    n_tests++; if (!seen || ifa.p_re !== 16'sd32767) begin n_fail++; $display("FAIL sat_re: got %0d expected 32767", ifa.p_re); end
    n_tests++; if (ifa.p_im !== 16'sd0) begin n_fail++; $display("FAIL sat_im: got %0d expected 0", ifa.p_im); end
    n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_set: got %b expected 1", ovf_a); end
    repeat (5) step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b expected 1", ovf_a); end
    step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b1, acc, got);
    step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_clear: got %b expected 0", ovf_a); end
    exp_idx = 0;
  endtask

  task automatic test_frame_backpressure();
    logic               acc, got, iv, ordy;
    int                 sent, rcv;
    bit                 prev_stall;
    logic signed [15:0] h_re;
    logic [3:0]         h_idx;
    logic               h_last;
    sent = 0; rcv = 0; prev_stall = 1'b0;
    h_re = '0; h_idx = '0; h_last = 1'b0;
    for (int cyc = 0; cyc < 400 && rcv < 20; cyc++) begin
      iv   = (sent < 20) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(iv, 16'(2 * sent), 16'sd0, 16'(2 * sent + 1), 16'sd0, 1'b0, ordy, 1'b0, acc, got);
      if (prev_stall) begin
        n_tests++;
        if (ifc.out_valid !== 1'b1 || ifc.p_re !== h_re || ifc.p_idx !== h_idx || ifc.p_last !== h_last) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b re=%0d idx=%0d last=%b expected v=1 re=%0d idx=%0d last=%b",
                   ifc.out_valid, ifc.p_re, ifc.p_idx, ifc.p_last, h_re, h_idx, h_last);
        end
      end
      prev_stall = ifc.out_valid && !ordy;
      h_re = ifc.p_re; h_idx = ifc.p_idx; h_last = ifc.p_last;
      if (got) begin
        n_tests++; if (ifc.p_re !== 16'(2 * rcv * (2 * rcv + 1))) begin n_fail++; $display("FAIL frame_val[%0d]: got %0d expected %0d", rcv, ifc.p_re, 2 * rcv * (2 * rcv + 1)); end
        n_tests++; if (ifc.p_idx !== 4'(rcv % 16)) begin n_fail++; $display("FAIL frame_idx[%0d]: got %0d expected %0d", rcv, ifc.p_idx, rcv % 16); end
        n_tests++; if (ifc.p_last !== (rcv % 16 == 15)) begin n_fail++; $display("FAIL frame_last[%0d]: got %b expected %b", rcv, ifc.p_last, (rcv % 16 == 15)); end
        rcv++;
      end
      if (acc) sent++;
    end
    n_tests++; if (rcv != 20 || sent != 20) begin n_fail++; $display("FAIL frame_count: got %0d results from %0d beats expected 20", rcv, sent); end
    exp_idx = 4;
  endtask

  task automatic test_random();
    logic               acc, got, iv, ordy, cj;
    logic signed [15:0] ar, ai, br, bi;
    bit                 exp_ovf;
    exp_t               e;
    sbq.delete();
    step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b1, acc, got);
    exp_idx = 0;
    exp_ovf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      iv   = (cyc < 340) && ($urandom_range(0, 4) != 0);
      ordy = (cyc >= 340) || ($urandom_range(0, 3) != 0);
      ar = rnd_op(); ai = rnd_op(); br = rnd_op(); bi = rnd_op();
      cj = 1'($urandom);
      step(iv, ar, ai, br, bi, cj, ordy, 1'b0, acc, got);
      if (got) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rand_extra: got unexpected result re=%0d expected none", ifa.p_re);
        end else begin
          e = sbq.pop_front();
          n_tests++; if (ifa.p_re !== e.re_a) begin n_fail++; $display("FAIL rand_re_a: got %0d expected %0d", ifa.p_re, e.re_a); end
          n_tests++; if (ifa.p_im !== e.im_a) begin n_fail++; $display("FAIL rand_im_a: got %0d expected %0d", ifa.p_im, e.im_a); end
          n_tests++; if (ifb.p_re !== e.re_b) begin n_fail++; $display("FAIL rand_re_b: got %0d expected %0d", ifb.p_re, e.re_b); end
          n_tests++; if (ifb.p_im !== e.im_b) begin n_fail++; $display("FAIL rand_im_b: got %0d expected %0d", ifb.p_im, e.im_b); end
          n_tests++; if (ifc.p_re !== e.re_c) begin n_fail++; $display("FAIL rand_re_c: got %0d expected %0d", ifc.p_re, e.re_c); end
          n_tests++; if (ifc.p_im !== e.im_c) begin n_fail++; $display("FAIL rand_im_c: got %0d expected %0d", ifc.p_im, e.im_c); end
          n_tests++; if (ifa.p_idx !== e.idx) begin n_fail++; $display("FAIL rand_idx: got %0d expected %0d", ifa.p_idx, e.idx); end
          n_tests++; if (ifa.p_last !== e.last) begin n_fail++; $display("FAIL rand_last: got %b expected %b", ifa.p_last, e.last); end
        end
      end
      if (acc) begin
        push_exp(ar, ai, br, bi, cj);
        exp_ovf = exp_ovf | sbq[sbq.size() - 1].clip_a;
      end
    end
    n_tests++; if (sbq.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d results outstanding expected 0", sbq.size()); end
    n_tests++; if (ovf_a !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf: got %b expected %b", ovf_a, exp_ovf); end
  endtask

  task automatic test_reset_mid();
    logic acc, got;
    int   n_out;
    step(1'b1, 16'sd1000, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    step(1'b1, 16'sd1200, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    step(1'b1, 16'sd1400, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0, 1'b0, acc, got);
    n_tests++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", ifa.out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", ifa.out_valid); end
    n_tests++; if (ifa.p_re !== 16'sd0) begin n_fail++; $display("FAIL rmid_p_re: got %0d expected 0", ifa.p_re); end
    repeat (2) step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    rst_n = 1'b1;
    exp_idx = 0;
    step(1'b1, 16'sd4096, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
    n_out = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0, acc, got);
      if (got) begin
        if (n_out == 0) begin
          n_tests++; if (ifa.p_re !== 16'sd2048) begin n_fail++; $display("FAIL rmid_first_re: got %0d expected 2048", ifa.p_re); end
          n_tests++; if (ifa.p_idx !== 4'd0) begin n_fail++; $display("FAIL rmid_first_idx: got %0d expected 0", ifa.p_idx); end
        end
        n_out++;
      end
    end
    n_tests++; if (n_out != 1) begin n_fail++; $display("FAIL rmid_out_count: got %0d expected 1", n_out); end
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.a_re      = '0;
    ifa.a_im      = '0;
    ifa.b_re      = '0;
    ifa.b_im      = '0;
    ifa.conj_b    = 1'b0;
    ifa.out_ready = 1'b1;
    test_reset();
    test_real();
    test_conj();
    test_round();
    test_saturation();
    test_frame_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmplx_mult_stream.md
Name: cmplx_mult_stream

Overview:
Pipelined, parametrised complex multiplier for the DFT datapath. It replaces the fixed 16-point, combinational, double-precision element-wise multiply with a streaming, fixed-point signed Qm.FRAC engine. The block accepts one complex pair per cycle under valid/ready flow control and tags each result with its element index within a FRAME-point vector. It adds a per-beat conjugate mode, selectable rounding, saturation, and a sticky overflow flag.

Parameters:
W, 16, signed width of each real/imag component (inputs and outputs)
FRAC, 15, fractional bits; product is scaled by 2^-FRAC
FRAME, 16, elements per vector; index counter range 0..FRAME-1 (FRAME>=2)
ROUND, 1, 1 = round-half-up before scaling, 0 = truncate (floor)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
a_re, a_im  in  W each  operand A, signed
b_re, b_im  in  W each  operand B, signed
conj_b  in  1  1 = use conj(B) for this beat
clear  in  1  synchronous clear of ovf and index counter
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
p_re, p_im  out  W each  product, signed, saturated
p_idx  out  $clog2(FRAME)  element index of this result
p_last  out  1  high when p_idx == FRAME-1
ovf  out  1  sticky: any saturation since reset/clear

Behaviour:
- Reset (async, rst_n=0): all stage valids=0, out_valid=0, p_re/p_im/p_idx=0, p_last=0, ovf=0, index counter=0. Asserting reset mid-frame discards in-flight beats; after release the next accepted beat is index 0.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Beat accepted when in_valid && in_ready.
- Three register stages; all advance together on adv; valid bits travel with data, so bubbles are preserved. Latency from acceptance to out_valid is 3 cycles with no stall. Throughput is 1 beat/cycle.
- Stall (out_valid && !out_ready): all stages hold, and outputs hold stable until accepted.
- S1: register operands, conj_b, index, and last. On acceptance, the index counter increments, wrapping FRAME-1 -> 0.
- S2: four signed 2W-bit products: ar*br, ai*bi, ar*bi, ai*br.
- S3: sums are 2W+1 bits.
  - conj_b=0: re = ar*br - ai*bi; im = ar*bi + ai*br.
  - conj_b=1: re = ar*br + ai*bi; im = ai*br - ar*bi.
  - ROUND=1: add 2^(FRAC-1) to each sum, then arithmetic shift right by FRAC. ROUND=0: shift only.
  - Saturate each component to [-2^(W-1), 2^(W-1)-1]. If either component clips, ovf<=1 when the beat leaves S3.
- clear=1: index counter <= 0 and ovf <= 0 in the same cycle. In-flight beats keep their already-assigned indices. If clear coincides with an acceptance, the accepted beat takes index 0 and the counter becomes 1. If clear coincides with a saturating beat leaving S3, ovf ends at 1.
- p_last is derived from the registered index, never from the output handshake.

Test Plan:
- Real product, W=16 FRAC=15 ROUND=1: a=(16384,0), b=(16384,0) -> p=(8192,0) three cycles after acceptance; ovf=0.
- Complex and conjugate: a=(16384,16384), b=(16384,-16384), conj_b=0 -> p=(16384,0). Same operands with conj_b=1 -> p=(0,16384).
- Saturation: a=(-32768,0), b=(-32768,0) -> p_re=32767, p_im=0, ovf=1; ovf stays 1 until a clear pulse, then reads 0.
- Rounding: a=(1,0), b=(16384,0) -> p_re=1 with ROUND=1; p_re=0 with a ROUND=0 instance. a=(-1,0), b=(16384,0) -> 0 (ROUND=1), -1 (ROUND=0).
- Frame and backpressure: stream 20 beats with a[r]=(2r,0), b[r]=(2r+1,0), FRAC=0, and randomly drop out_ready.
  - Results must be 2r*(2r+1) in order, with no loss or duplication.
  - p_idx runs 0..15 then 0..3; p_last is high only on index 15.
  - Outputs stay stable while stalled.
- Reset mid-operation: drop rst_n with 2 beats in flight -> out_valid=0 immediately. After release, the first output is p_idx=0 and nothing stale appears.
